hbridge_drive_sequencer: RTL and testbench

- Drives the H-bridge DIR/EN pair of the motor header from software-written duty and direction requests.
- Generates the EN PWM, and sequences every direction reversal: ramp duty to zero, enforce a dead time, flip DIR, resume.
- Sits inside embsys between the control-register GPIO outputs and the DIR/EN pins.
- Guarantees DIR never changes while EN can be high.

---
 rtl/hbridge_drive_sequencer_pkg.sv | 22 ++
 rtl/hbridge_drive_sequencer_pwm_gen.sv | 40 ++++
 rtl/hbridge_drive_sequencer.sv | 111 +++++++++++
 tb/tb_hbridge_drive_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_drive_sequencer_pkg.sv
// Shared definitions for the H-bridge drive sequencer: FSM state encoding
// (also decoded by the embsys status GPIO) and default timing constants.
package hbridge_drive_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RAMP = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_PRESCALE = 16;
  localparam int DEF_RAMP_DIV = 4096;
  localparam int DEF_DEADTIME = 100000;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hbridge_drive_sequencer_pwm_gen.sv
// Free-running prescaled PWM counter with a registered duty compare.
// EN is only allowed high while gate is asserted.
module hbridge_drive_sequencer_pwm_gen
  import hbridge_drive_sequencer_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                gate,
  input  logic [PWM_BITS-1:0] duty,
  output logic                en
);

  localparam int PS_W = cnt_width(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = (presc == PS_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc   <= '0;
      pwm_cnt <= '0;
      en      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      // Strict less-than: duty 0 never drives EN, full scale leaves one low tick.
      en <= gate && (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/hbridge_drive_sequencer.sv
// H-bridge DIR/EN sequencer: tracks requested duty, and on a direction change
// ramps duty to zero, holds EN low for a dead time, then flips DIR.
module hbridge_drive_sequencer
  import hbridge_drive_sequencer_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int RAMP_DIV = DEF_RAMP_DIV,
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable_req,
  input  logic                dir_req,
  input  logic [PWM_BITS-1:0] duty_req,
  output logic                EN,
  output logic                DIR,
  output logic [PWM_BITS-1:0] duty_act,
  output logic                busy,
  output logic [1:0]          state
);

  localparam int RW = cnt_width(RAMP_DIV);
  localparam int DW = cnt_width(DEADTIME);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);

  state_t        st;
  logic [RW-1:0] ramp_cnt;
  logic [DW-1:0] dead_cnt;
  logic          gate;

  assign state = st;
  assign busy  = (st == ST_RAMP) || (st == ST_DEAD);
  // Qualifying with enable_req makes a disable force EN low on the very next edge.
  assign gate  = enable_req && ((st == ST_RUN) || (st == ST_RAMP));

  hbridge_drive_sequencer_pwm_gen #(
    .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE)
  ) u_pwm (
    .clk   (clk),
    .resetn(resetn),
    .gate  (gate),
    .duty  (duty_act),
    .en    (EN)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st       <= ST_IDLE;
      DIR      <= 1'b1;
      duty_act <= '0;
      ramp_cnt <= '0;
      dead_cnt <= '0;
    end else if (!enable_req) begin
      st       <= ST_IDLE;
      duty_act <= '0;
      ramp_cnt <= '0;
      dead_cnt <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          duty_act <= '0;
          if (dir_req == DIR) begin
            st <= ST_RUN;
          end else begin
            st       <= ST_DEAD;
            dead_cnt <= DEAD_LAST;
          end
        end
        ST_RUN: begin
          if (dir_req != DIR) begin
            st       <= ST_RAMP;
            ramp_cnt <= '0;
          end else begin
            duty_act <= duty_req;
          end
        end
        ST_RAMP: begin
          if (dir_req == DIR) begin
            st       <= ST_RUN;
            ramp_cnt <= '0;
          end else if (ramp_cnt == RAMP_LAST) begin
            ramp_cnt <= '0;
            if (duty_act == '0) begin
              st       <= ST_DEAD;
              dead_cnt <= DEAD_LAST;
            end else begin
              duty_act <= duty_act - 1'b1;
            end
          end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
          end
        end
        ST_DEAD: begin
          // EN has been low for the whole window, so DIR may move here only.
          if (dead_cnt == '0) begin
            DIR      <= dir_req;
            st       <= ST_RUN;
            duty_act <= '0;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_drive_sequencer.sv
// Directed bench for hbridge_drive_sequencer with a cycle-tagged expected queue.
module tb_hbridge_drive_sequencer;

  localparam int PWM_BITS = 4;

  localparam int K_STATE = 0;
  localparam int K_DIR   = 1;
  localparam int K_DUTY  = 2;
  localparam int K_EN    = 3;
  localparam int K_BUSY  = 4;
  localparam int K_ENCNT = 5;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic                clk = 1'b0;
  logic                resetn;
  logic                enable_req;
  logic                dir_req;
  logic [PWM_BITS-1:0] duty_req;
  logic                en;
  logic                dir;
  logic [PWM_BITS-1:0] duty_act;
  logic                busy;
  logic [1:0]          state;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hbridge_drive_sequencer #(
    .PWM_BITS(PWM_BITS),
    .PRESCALE(1),
    .RAMP_DIV(2),
    .DEADTIME(5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable_req(enable_req),
    .dir_req   (dir_req),
    .duty_req  (duty_req),
    .EN        (en),
    .DIR       (dir),
    .duty_act  (duty_act),
    .busy      (busy),
    .state     (state)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int off, input int kind, input int val);
    exp_t e;
    int   i;
    e.cyc  = cyc + off;
    e.kind = kind;
    e.val  = val;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > e.cyc) i--;
    exp_q.insert(i, e);
  endtask

  function automatic string kind_name(input int kind);
    case (kind)
      K_STATE: return "state";
      K_DIR:   return "dir";
      K_DUTY:  return "duty_act";
      K_EN:    return "en";
      K_BUSY:  return "busy";
      default: return "en_count16";
    endcase
  endfunction

  // scoreboard monitor
  logic [15:0] en_hist = '0;
  logic        prev_dir;
  logic        prev_en;

  always @(negedge clk) begin
    exp_t e;
    int   got;
    en_hist = {en_hist[14:0], (en === 1'b1)};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_STATE: got = int'(state);
        K_DIR:   got = int'(dir);
        K_DUTY:  got = int'(duty_act);
        K_EN:    got = int'(en);
        K_BUSY:  got = int'(busy);
        default: got = $countones(en_hist);
      endcase
      checks++;
      if (got != e.val || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s @cycle %0d (due %0d): got %0d expected %0d",
                 kind_name(e.kind), cyc, e.cyc, got, e.val);
      end
    end
    if (cyc >= 2 && dir !== prev_dir) begin
      checks++;
      if (en !== 1'b0 || prev_en !== 1'b0) begin
        errors++;
        $display("FAIL dir_change_with_en @cycle %0d: en=%b prev_en=%b expected 0/0",
                 cyc, en, prev_en);
      end
    end
    prev_dir = dir;
    prev_en  = en;
  end

  initial begin
    resetn     = 1'b0;
    enable_req = 1'b1;
    dir_req    = 1'b1;
    duty_req   = 4'd4;

    // reset held three cycles with enable requested
    for (int k = 1; k <= 3; k++) begin
      exp_at(k, K_EN, 0);
      exp_at(k, K_DIR, 1);
      exp_at(k, K_STATE, 0);
      exp_at(k, K_DUTY, 0);
      exp_at(k, K_BUSY, 0);
    end
    step(3);
    resetn = 1'b1;
    exp_at(1, K_STATE, 1);
    exp_at(2, K_DUTY, 4);
    exp_at(20, K_ENCNT, 4);
    step(20);

    // steady PWM at duty 0 and full scale
    duty_req = 4'd0;
    exp_at(1, K_DUTY, 0);
    exp_at(20, K_ENCNT, 0);
    step(20);
    duty_req = 4'd15;
    exp_at(1, K_DUTY, 15);
    exp_at(20, K_ENCNT, 15);
    step(20);

    // aborted reversal: back to the original direction after 3 RAMP cycles
    duty_req = 4'd3;
    step(4);
    dir_req = 1'b0;
    exp_at(1, K_STATE, 2);
    exp_at(1, K_BUSY, 1);
    exp_at(1, K_DUTY, 3);
    exp_at(3, K_DUTY, 2);
    step(3);
    dir_req = 1'b1;
    exp_at(1, K_STATE, 1);
    exp_at(1, K_BUSY, 0);
    exp_at(1, K_DIR, 1);
    exp_at(2, K_DUTY, 3);
    step(4);

    // full reversal 1 -> 0
    dir_req = 1'b0;
    exp_at(1, K_STATE, 2);
    exp_at(3, K_DUTY, 2);
    exp_at(5, K_DUTY, 1);
    exp_at(7, K_DUTY, 0);
    exp_at(7, K_STATE, 2);
    exp_at(9, K_STATE, 3);
    exp_at(9, K_EN, 0);
    exp_at(13, K_STATE, 3);
    exp_at(13, K_DIR, 1);
    exp_at(13, K_EN, 0);
    exp_at(14, K_STATE, 1);
    exp_at(14, K_DIR, 0);
    exp_at(14, K_EN, 0);
    exp_at(14, K_BUSY, 0);
    exp_at(15, K_DUTY, 3);
    step(16);

    // disable during RAMP
    dir_req = 1'b1;
    exp_at(1, K_STATE, 2);
    step(2);
    enable_req = 1'b0;
    exp_at(1, K_STATE, 0);
    exp_at(1, K_DUTY, 0);
    exp_at(1, K_EN, 0);
    exp_at(1, K_DIR, 0);
    exp_at(1, K_BUSY, 0);
    step(3);

    // disable during DEAD (entered straight from IDLE)
    enable_req = 1'b1;
    exp_at(1, K_STATE, 3);
    exp_at(1, K_BUSY, 1);
    step(2);
    enable_req = 1'b0;
    exp_at(1, K_STATE, 0);
    exp_at(1, K_DIR, 0);
    exp_at(1, K_EN, 0);
    exp_at(1, K_DUTY, 0);
    step(3);

    // reset at dead count 2, then a full dead time before the flip
    enable_req = 1'b1;
    exp_at(1, K_STATE, 3);
    step(3);
    resetn = 1'b0;
    exp_at(1, K_STATE, 0);
    exp_at(1, K_DIR, 1);
    exp_at(1, K_EN, 0);
    exp_at(1, K_DUTY, 0);
    exp_at(1, K_BUSY, 0);
    step(1);
    resetn  = 1'b1;
    dir_req = 1'b0;
    exp_at(1, K_STATE, 3);
    exp_at(5, K_STATE, 3);
    exp_at(5, K_DIR, 1);
    exp_at(6, K_STATE, 1);
    exp_at(6, K_DIR, 0);
    step(8);

    // drain with a bound
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
